// File: rtl/ring_pkg.sv
// Shared constants and types for the ring sequencer consumers.
package ring_pkg;
  localparam logic [2:0] PH_IDLE = 3'b000;
  localparam logic [2:0] PH_L0   = 3'b001;
  localparam logic [2:0] PH_L1   = 3'b010;
  localparam logic [2:0] PH_L2   = 3'b100;

  localparam int OUT_DEPTH = 2;

  // Assembler state: which lane the next in-order byte must carry.
  typedef enum logic [1:0] {
    EXP0 = 2'd0,
    EXP1 = 2'd1,
    EXP2 = 2'd2
  } asm_state_t;
endpackage

// File: rtl/ring_phase_packer_if.sv
// Byte-in / word-out bus between the ring front end and the packer.
interface ring_phase_packer_if #(
  parameter int DATA_W = 8
) ();
  logic [2:0]          phase;
  logic                phase_flush;
  logic [DATA_W-1:0]   din;
  logic                din_valid;
  logic [3*DATA_W-1:0] word_out;
  logic                word_valid;
  logic                word_ready;
  logic [1:0]          word_level;
  logic                phase_err;
  logic                overrun;

  modport master (
    output phase, phase_flush, din, din_valid, word_ready,
    input  word_out, word_valid, word_level, phase_err, overrun
  );

  modport slave (
    input  phase, phase_flush, din, din_valid, word_ready,
    output word_out, word_valid, word_level, phase_err, overrun
  );
endinterface

// File: rtl/ring_word_fifo.sv
// Two-entry register FIFO; entry 0 is always the head, so the head is a
// plain register output. A push that finds the FIFO full without a
// simultaneous pop is ignored (the caller flags it).
module ring_word_fifo
  import ring_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       level,
  output logic             full
);
  logic [WIDTH-1:0] mem0;
  logic [WIDTH-1:0] mem1;

  assign head = mem0;
  assign full = (level == 2'(OUT_DEPTH));

  // Storage and occupancy update; pop is only asserted when non-empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem0  <= '0;
      mem1  <= '0;
      level <= 2'd0;
    end else begin
      case (level)
        2'd0: begin
          if (push) begin
            mem0  <= push_data;
            level <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            mem0 <= push_data;
          end else if (push) begin
            mem1  <= push_data;
            level <= 2'd2;
          end else if (pop) begin
            level <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            mem0 <= mem1;
            if (push) mem1 <= push_data;
            else      level <= 2'd1;
          end
        end
        default: level <= 2'd0;
      endcase
    end
  end
endmodule

// File: rtl/ring_phase_packer.sv
// Packs a phase-tagged byte stream into 3-lane words and buffers them for
// a valid/ready consumer. Lane order is enforced; errors are sticky.
module ring_phase_packer
  import ring_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  ring_phase_packer_if.slave bus
);
  asm_state_t          state_q, state_d;
  logic [DATA_W-1:0]   lane0_q, lane1_q;
  logic                wr_lane0, wr_lane1, clr_lanes, push, err_set;
  logic                pop, full, ovr_set;
  logic [1:0]          level;
  logic [3*DATA_W-1:0] head;
  logic                phase_err_q, overrun_q;

  assign pop     = (level != 2'd0) && bus.word_ready;
  assign ovr_set = push && full && !pop;

  // Assembler next-state: lane steering, word completion and error detect.
  always_comb begin
    state_d   = state_q;
    wr_lane0  = 1'b0;
    wr_lane1  = 1'b0;
    clr_lanes = 1'b0;
    push      = 1'b0;
    err_set   = 1'b0;
    if (bus.phase_flush) begin
      state_d   = EXP0;
      clr_lanes = 1'b1;
    end else if (bus.din_valid) begin
      case (bus.phase)
        PH_IDLE: ;
        PH_L0: begin
          wr_lane0 = 1'b1;
          state_d  = EXP1;
          err_set  = (state_q != EXP0);
        end
        PH_L1: begin
          if (state_q == EXP1) begin
            wr_lane1 = 1'b1;
            state_d  = EXP2;
          end else begin
            err_set = 1'b1;
          end
        end
        PH_L2: begin
          if (state_q == EXP2) begin
            push    = 1'b1;
            state_d = EXP0;
          end else begin
            err_set = 1'b1;
          end
        end
        default: err_set = 1'b1;
      endcase
    end
  end

  // Assembler state, lane registers and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= EXP0;
      lane0_q     <= '0;
      lane1_q     <= '0;
      phase_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clr_lanes) begin
        lane0_q <= '0;
        lane1_q <= '0;
      end else begin
        if (wr_lane0) begin
          lane0_q <= bus.din;
          lane1_q <= '0;
        end
        if (wr_lane1) lane1_q <= bus.din;
      end
      if (err_set) phase_err_q <= 1'b1;
      if (ovr_set) overrun_q   <= 1'b1;
    end
  end

  ring_word_fifo #(
    .WIDTH(3*DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({bus.din, lane1_q, lane0_q}),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .full      (full)
  );

  assign bus.word_out   = head;
  assign bus.word_valid = (level != 2'd0);
  assign bus.word_level = level;
  assign bus.phase_err  = phase_err_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: doc/ring_phase_packer.md
# ring_phase_packer

Downstream consumer of the 3-bit one-hot ring sequencer. Samples a byte stream against the ring's phase vector, steers bytes into lanes 0/1/2 of a 3*DATA_W word, and hands completed words to the next stage through a 2-entry valid/ready output buffer. Lane order is enforced, phase errors and buffer overruns are flagged sticky, and a flush input discards any partially assembled word.

## Interface
- DATA_W, 8, byte lane width
- clk  in  1  single clock, rising-edge
- reset  in  1  synchronous, active-low (0 = in reset, sampled on clk rising edge)
- phase  in  3  ring state vector: 3'b001 lane0, 3'b010 lane1, 3'b100 lane2, 3'b000 idle
- phase_flush  in  1  same-cycle copy of the ring's flush request; discards partial word
- din  in  DATA_W  input byte
- din_valid  in  1  din qualifies this cycle (no backpressure upstream)
- word_out  out  3*DATA_W  head of output buffer; lane0 in [DATA_W-1:0], lane2 in MSBs
- word_valid  out  1  output buffer non-empty
- word_ready  in  1  downstream accepts word_out when word_valid
- word_level  out  2  output buffer occupancy, 0..2
- phase_err  out  1  sticky: byte offered with non-one-hot, non-zero phase, or out-of-order lane
- overrun  out  1  sticky: completed word dropped because buffer full

## Operation
- Assembler FSM: states EXP0, EXP1, EXP2 (expected lane). Reset and flush -> EXP0, partial lanes cleared to 0.
- Accept condition: din_valid=1 and phase one-hot.
- phase=001 with valid: always accepted into lane0, FSM -> EXP1 (resync; if FSM was EXP1/EXP2, partial word discarded, phase_err set).
- phase=010 in EXP1: lane1 <= din, -> EXP2. phase=100 in EXP2: lane2 <= din, word complete, push, -> EXP0.
- phase=010/100 when not the expected lane: byte dropped, phase_err set, FSM unchanged.
- phase=000 with valid: byte ignored, no error. Phase 011/101/110/111 with valid: byte ignored, phase_err set.
- din_valid=0: no state change regardless of phase.
- phase_flush=1: wins over any byte that cycle; assembler -> EXP0; output buffer contents kept.
- Output buffer: 2-entry FIFO. Pop when word_valid & word_ready. Push on word complete.
- Push when level=2 and no pop same cycle: word dropped, overrun set, buffer unchanged. Push+pop same cycle at level=2: both occur, level stays 2, no overrun. Push+pop at level=1: level stays 1, head advances.
- Sticky flags cleared only by reset.

## Timing
- Reset values: word_out=0, word_valid=0, word_level=0, phase_err=0, overrun=0, FSM=EXP0.
- All outputs registered; no combinational path from word_ready or din to any output.
- Latency: lane2 byte accepted at edge N -> word_valid=1 and word_out valid after edge N when buffer was empty.
- Max throughput: one word per 3 cycles (phase advances each clock).
- Pop at edge N -> next entry on word_out after edge N; word_out holds stable while word_valid=1 and word_ready=0.
- Reset mid-word or with full buffer: all state cleared at the next edge, in-flight words lost, no flags set.

## Structure
- Shared package ring_pkg: constants PH_IDLE=3'b000, PH_L0=3'b001, PH_L1=3'b010, PH_L2=3'b100; assembler state enum (EXP0/EXP1/EXP2); OUT_DEPTH=2.
- One sub-module: ring_word_fifo (2-entry register FIFO, parameterised width, push/pop/level, synchronous active-low reset).
- Assembler FSM, lane registers and error logic live in ring_phase_packer.

## Test plan
- Phases 001,010,100 with din 0x11,0x22,0x33, word_ready=1 -> word_out=0x332211, word_valid one cycle, no flags.
- Three words streamed, word_ready=0 -> level 1, 2, third word dropped, overrun=1, word_out stays first word; raise ready -> first two words drained in order.
- Phase 001 then 100 with valid (skip lane1) -> byte dropped, phase_err=1, FSM stays EXP1; following 010,100 completes word.
- Phase 011 with valid -> phase_err=1, no push; phase 000 with valid -> ignored, no error.
- phase_flush asserted after lane1 accepted -> partial word discarded; next 001,010,100 with 0xA1,0xB2,0xC3 -> 0xC3B2A1.
- reset=0 asserted with level=2 and FSM in EXP2 -> after one edge all outputs 0, flags 0; push at level 2 with simultaneous pop -> level 2, no overrun.
